fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised successor to the IF/ID pipeline register. Buffers fetched PC/instruction pairs in a DEPTH-entry FIFO while the pipeline is stalled, so no instruction-memory returns are lost.
- Replaces the fixed two-slot stall buffer and fixed two-bubble flush with configurable depth and bubble count.
- Adds full/count/overflow visibility.
- Sits between the instruction-memory read port and the ID stage; its output register is the IF/ID register.

Parameters:
XLEN, 32, width of PC and instruction words
DEPTH, 4, FIFO entries (any value >= 1, need not be a power of two)
FLUSH_BUBBLES, 2, extra NOP cycles after the flush cycle (0 allowed)
CNT_W, $clog2(DEPTH+1), width of count

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
enq_valid  in  1  fetch word present this cycle
enq_pc  in  XLEN  PC of fetched word
enq_instr  in  XLEN  fetched instruction
stall  in  1  freeze ID output (hazard stall OR memory not ready OR ALU not ready)
flush  in  1  taken branch/jump from EX
pc_id  out  XLEN  PC presented to ID
instruction_id  out  XLEN  instruction presented to ID (NOP = 32'h0)
valid_id  out  1  instruction_id is a real instruction
full  out  1  count == DEPTH
count  out  CNT_W  occupied FIFO entries
overflow  out  1  sticky: an enqueue was discarded because the FIFO was full

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (asynchronous, takes effect immediately):
  - pc_id = 0, instruction_id = 0, valid_id = 0.
  - FIFO pointers = 0, count = 0, drop counter = 0, overflow = 0.
- Per rising edge, first matching rule applies:
  1. stall = 1:
     - Output register holds.
     - If enq_valid and not full: push {enq_pc, enq_instr}.
     - If enq_valid and full: discard the word and set overflow.
     - flush is ignored this cycle; upstream holds flush asserted until stall drops.
  2. flush = 1:
     - FIFO emptied: pointers reset, count = 0.
     - instruction_id <= 0, valid_id <= 0, pc_id <= enq_pc.
     - drop counter <= FLUSH_BUBBLES.
     - enq word discarded.
  3. drop counter > 0:
     - instruction_id <= 0, valid_id <= 0, pc_id <= enq_pc.
     - enq word discarded; drop counter decrements.
  4. Normal, FIFO non-empty:
     - Output register <= FIFO head, valid_id <= 1, pop.
     - If enq_valid, push in the same cycle; count unchanged.
  5. Normal, FIFO empty (bypass, latency 1):
     - pc_id <= enq_pc.
     - instruction_id <= enq_instr if enq_valid, else 0.
     - valid_id <= enq_valid.
- Ordering: FIFO order is strict; output order equals enqueue order.
- Pointers: read/write pointers wrap from DEPTH-1 to 0.
- Push and pop in one cycle are legal even when full, because the pop frees the slot first.
- Register-only outputs: full = (count == DEPTH). count and full are registered. No combinational path from inputs to any output.
- overflow clears only on reset.

Decomposition:
- Shared package (core_pkg):
  - XLEN default.
  - NOP_INSTR = 32'h0.
  - FETCH_ENTRY struct {pc, instr}.
- One sub-module: fetch_fifo_mem.
  - DEPTH x 2*XLEN storage with wrapping read/write pointers and an occupancy counter.
  - Controls: push, pop, clear.
- Top level contains the output register, drop counter and priority logic.

Test Plan:
1. No stall; enqueue (0x0,A), (0x4,B), (0x8,C) on consecutive cycles -> the same pairs appear at pc_id/instruction_id one cycle later each, valid_id = 1, count stays 0.
2. stall = 1 for 2 cycles while enqueuing (0x10,D), (0x14,E):
   - Output holds and count = 2 during the stall.
   - Release stall, enq_valid = 0 -> outputs D, E on the next two edges; count goes 2 -> 1 -> 0.
3. DEPTH = 4, stall = 1, five consecutive enqueues -> full = 1 after the 4th, overflow = 1 after the 5th. After release, exactly four words drain in order and the 5th never appears.
4. count = 3, then flush = 1 with stall = 0:
   - count = 0 next cycle.
   - instruction_id = 0 and valid_id = 0 for 3 cycles (flush + FLUSH_BUBBLES = 2), while enqueues 0x40, 0x44 are discarded.
   - Enqueue 0x48 in the 4th cycle -> shown with valid_id = 1.
5. flush = 1 while stall = 1 -> no state change except an enqueue. Keep flush = 1 as stall falls -> the flush applies on that edge.
6. Mid-stall with count = 2, overflow = 1: assert rst between clock edges -> all outputs and count = 0 and overflow = 0 immediately, before the next edge.

Source files
------------

// File: rtl/core_pkg.sv
// ============================================================================
//  core_pkg : shared widths, NOP encoding and fetch-entry layout
//  Revision : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo_mem.sv
// ============================================================================
//  fetch_fifo_mem : DEPTH x 2*XLEN ring buffer with push/pop/clear and count
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo_mem
   import core_pkg::*;
#(
   parameter int XLEN  = core_pkg::XLEN,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_clear,
   input  logic [2*XLEN-1:0] i_wdata,
   output logic [2*XLEN-1:0] o_rdata,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_full,
   output logic              o_empty
);

   localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

   logic [2*XLEN-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_full;
   logic [CNT_W-1:0]  w_count_nxt;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == C_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      w_count_nxt = r_count;
      if (i_clear)
         w_count_nxt = '0;
      else if (i_push && !i_pop)
         w_count_nxt = r_count + CNT_W'(1);
      else if (!i_push && i_pop)
         w_count_nxt = r_count - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == C_DEPTH);
         if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_clear)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = r_full;
   assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
//  fetch_queue : IF/ID register fronted by a stall FIFO, with flush bubbles
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
   import core_pkg::*;
#(
   parameter int XLEN          = core_pkg::XLEN,
   parameter int DEPTH         = 4,
   parameter int FLUSH_BUBBLES = 2,
   parameter int CNT_W         = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_enq_valid,
   input  logic [XLEN-1:0]  i_enq_pc,
   input  logic [XLEN-1:0]  i_enq_instr,
   input  logic             i_stall,
   input  logic             i_flush,
   output logic [XLEN-1:0]  o_pc_id,
   output logic [XLEN-1:0]  o_instruction_id,
   output logic             o_valid_id,
   output logic             o_full,
   output logic [CNT_W-1:0] o_count,
   output logic             o_overflow
);

   localparam int                DROP_W = (FLUSH_BUBBLES > 0) ? $clog2(FLUSH_BUBBLES + 1) : 1;
   localparam logic [DROP_W-1:0] C_DROP = DROP_W'(FLUSH_BUBBLES);
   localparam logic [XLEN-1:0]   C_NOP  = XLEN'(NOP_INSTR);

   logic [XLEN-1:0]   r_pc_id;
   logic [XLEN-1:0]   r_instr_id;
   logic              r_valid_id;
   logic              r_overflow;
   logic [DROP_W-1:0] r_drop;

   logic              w_push;
   logic              w_pop;
   logic              w_clear;
   logic              w_full;
   logic              w_empty;
   logic [2*XLEN-1:0] w_head;

   always_comb begin
      w_push  = 1'b0;
      w_pop   = 1'b0;
      w_clear = 1'b0;
      if (i_stall)
         w_push = i_enq_valid && !w_full;
      else if (i_flush)
         w_clear = 1'b1;
      else if (r_drop == '0 && !w_empty) begin
         w_pop  = 1'b1;
         w_push = i_enq_valid;
      end
   end

   fetch_fifo_mem #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (w_clear),
      .i_wdata ({i_enq_pc, i_enq_instr}),
      .o_rdata (w_head),
      .o_count (o_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Flush and bubble cycles still track the fetch PC so ID sees where fetch is.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc_id    <= '0;
         r_instr_id <= '0;
         r_valid_id <= 1'b0;
         r_overflow <= 1'b0;
         r_drop     <= '0;
      end else if (i_stall) begin
         if (i_enq_valid && w_full)
            r_overflow <= 1'b1;
      end else if (i_flush) begin
         r_pc_id    <= i_enq_pc;
         r_instr_id <= C_NOP;
         r_valid_id <= 1'b0;
         r_drop     <= C_DROP;
      end else if (r_drop != '0) begin
         r_pc_id    <= i_enq_pc;
         r_instr_id <= C_NOP;
         r_valid_id <= 1'b0;
         r_drop     <= r_drop - DROP_W'(1);
      end else if (!w_empty) begin
         r_pc_id    <= w_head[2*XLEN-1:XLEN];
         r_instr_id <= w_head[XLEN-1:0];
         r_valid_id <= 1'b1;
      end else begin
         r_pc_id    <= i_enq_pc;
         r_instr_id <= i_enq_valid ? i_enq_instr : C_NOP;
         r_valid_id <= i_enq_valid;
      end
   end

   assign o_pc_id          = r_pc_id;
   assign o_instruction_id = r_instr_id;
   assign o_valid_id       = r_valid_id;
   assign o_full           = w_full;
   assign o_overflow       = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
//  tb_fetch_queue : directed stimulus, queue-based reference model, literals
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;
   import core_pkg::*;

   localparam int DEPTH = 4;
   localparam int FB    = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            enq_valid = 1'b0;
   logic [31:0]     enq_pc    = '0;
   logic [31:0]     enq_instr = '0;
   logic            stall     = 1'b0;
   logic            flush     = 1'b0;
   logic [31:0]     pc_id, instruction_id;
   logic            valid_id, full, overflow;
   logic [CW-1:0]   count;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .FLUSH_BUBBLES(FB), .CNT_W(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_enq_valid      (enq_valid),
      .i_enq_pc         (enq_pc),
      .i_enq_instr      (enq_instr),
      .i_stall          (stall),
      .i_flush          (flush),
      .o_pc_id          (pc_id),
      .o_instruction_id (instruction_id),
      .o_valid_id       (valid_id),
      .o_full           (full),
      .o_count          (count),
      .o_overflow       (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue plus the architectural output values.
   fetch_entry_t m_q[$];
   fetch_entry_t m_e;
   int           m_drop;
   logic [31:0]  m_pc, m_instr;
   logic         m_valid, m_over;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_drop = 0; m_pc = 0; m_instr = 0; m_valid = 0; m_over = 0;
      end else if (stall) begin
         if (enq_valid) begin
            if (m_q.size() < DEPTH) m_q.push_back('{pc: enq_pc, instr: enq_instr});
            else                    m_over = 1'b1;
         end
      end else if (flush) begin
         m_q.delete();
         m_pc = enq_pc; m_instr = 0; m_valid = 0; m_drop = FB;
      end else if (m_drop > 0) begin
         m_pc = enq_pc; m_instr = 0; m_valid = 0; m_drop = m_drop - 1;
      end else if (m_q.size() > 0) begin
         m_e = m_q.pop_front();
         m_pc = m_e.pc; m_instr = m_e.instr; m_valid = 1'b1;
         if (enq_valid) m_q.push_back('{pc: enq_pc, instr: enq_instr});
      end else begin
         m_pc    = enq_pc;
         m_instr = enq_valid ? enq_instr : 32'h0;
         m_valid = enq_valid;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model.pc_id",    64'(pc_id),          64'(m_pc));
      chk("model.instr_id", 64'(instruction_id), 64'(m_instr));
      chk("model.valid_id", 64'(valid_id),       64'(m_valid));
      chk("model.count",    64'(count),          64'(m_q.size()));
      chk("model.full",     64'(full),           64'(m_q.size() == DEPTH));
      chk("model.overflow", 64'(overflow),       64'(m_over));
   end

   // Apply one cycle of inputs (called just after a falling edge).
   task automatic cyc(input logic ev, input logic [31:0] pc, input logic st, input logic fl);
      enq_valid = ev;
      enq_pc    = pc;
      enq_instr = 32'hA000_0000 | pc;
      stall     = st;
      flush     = fl;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset.valid", 64'(valid_id), 64'h0);
      chk("reset.count", 64'(count), 64'h0);
      rst = 1'b0;

      // 1: bypass, one-cycle latency
      cyc(1, 32'h0, 0, 0);
      chk("t1.pc0",    64'(pc_id), 64'h0);
      chk("t1.instr0", 64'(instruction_id), 64'hA000_0000);
      cyc(1, 32'h4, 0, 0);
      chk("t1.instr1", 64'(instruction_id), 64'hA000_0004);
      cyc(1, 32'h8, 0, 0);
      chk("t1.instr2", 64'(instruction_id), 64'hA000_0008);
      chk("t1.count",  64'(count), 64'h0);

      // 2: stall buffering then drain
      cyc(1, 32'h10, 1, 0);
      cyc(1, 32'h14, 1, 0);
      chk("t2.hold",   64'(pc_id), 64'h8);
      chk("t2.count2", 64'(count), 64'h2);
      cyc(0, 32'h0, 0, 0);
      chk("t2.D",      64'(instruction_id), 64'hA000_0010);
      chk("t2.count1", 64'(count), 64'h1);
      cyc(0, 32'h0, 0, 0);
      chk("t2.E",      64'(pc_id), 64'h14);
      chk("t2.count0", 64'(count), 64'h0);

      // 3: overflow on fifth enqueue
      for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 32'(4 * i), 1, 0);
      chk("t3.full",   64'(full), 64'h1);
      chk("t3.noovf",  64'(overflow), 64'h0);
      cyc(1, 32'h110, 1, 0);
      chk("t3.ovf",    64'(overflow), 64'h1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 32'h0, 0, 0);
         chk("t3.drain", 64'(pc_id), 64'(32'h100 + 32'(4 * i)));
      end
      cyc(0, 32'h0, 0, 0);
      chk("t3.no5th",  64'(valid_id), 64'h0);

      // 4: flush with three queued words
      for (int i = 0; i < 3; i++) cyc(1, 32'h200 + 32'(4 * i), 1, 0);
      chk("t4.count3", 64'(count), 64'h3);
      cyc(0, 32'h3C, 0, 1);
      chk("t4.cnt0",   64'(count), 64'h0);
      chk("t4.nop0",   64'(valid_id), 64'h0);
      cyc(1, 32'h40, 0, 0);
      chk("t4.nop1",   64'(instruction_id), 64'h0);
      cyc(1, 32'h44, 0, 0);
      chk("t4.nop2",   64'(valid_id), 64'h0);
      cyc(1, 32'h48, 0, 0);
      chk("t4.resume", 64'(instruction_id), 64'hA000_0048);
      chk("t4.valid",  64'(valid_id), 64'h1);

      // 5: flush held through a stall
      cyc(1, 32'h50, 1, 1);
      chk("t5.hold",   64'(pc_id), 64'h48);
      chk("t5.cnt1",   64'(count), 64'h1);
      cyc(0, 32'h54, 0, 1);
      chk("t5.flush",  64'(count), 64'h0);
      chk("t5.pc",     64'(pc_id), 64'h54);
      cyc(1, 32'h58, 0, 0);
      cyc(1, 32'h5C, 0, 0);
      chk("t5.bubble", 64'(valid_id), 64'h0);
      cyc(1, 32'h60, 0, 0);
      chk("t5.resume", 64'(pc_id), 64'h60);

      // 6: asynchronous reset mid-stall
      cyc(1, 32'h70, 1, 0);
      cyc(1, 32'h74, 1, 0);
      chk("t6.cnt2",   64'(count), 64'h2);
      chk("t6.ovf1",   64'(overflow), 64'h1);
      #2 rst = 1'b1;
      #1;
      chk("t6.rcount", 64'(count), 64'h0);
      chk("t6.rovf",   64'(overflow), 64'h0);
      chk("t6.rvalid", 64'(valid_id), 64'h0);
      chk("t6.rpc",    64'(pc_id), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      stall = 1'b0;
      cyc(1, 32'h80, 0, 0);
      chk("t6.after",  64'(instruction_id), 64'hA000_0080);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
